// File: rtl/output_interface_pkg.sv
// Shared image definitions: picture geometry, pixel/address widths and FSM state types
// for the BRAM-to-UART picture transmitter.
package output_interface_pkg;

    localparam int PIXELS_DEF = 276185;
    localparam int PIX_W      = 18;
    localparam int ADDR_W     = 19;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND,
        WAIT_TX,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_CLEANUP
    } tx_state_t;

    // Colour field idx (0=R, 1=G, 2=B) widened to a byte with its 6 bits in the MSBs.
    function automatic logic [7:0] color_byte(input logic [PIX_W-1:0] pix, input logic [1:0] idx);
        case (idx)
            2'd0:    return {pix[17:12], 2'b00};
            2'd1:    return {pix[11:6], 2'b00};
            default: return {pix[5:0], 2'b00};
        endcase
    endfunction

endpackage

// File: rtl/output_interface_uart_tx.sv
// 8N1 UART serializer, LSB first, idle high; Tx_Done pulses for one cycle after the stop bit.
module uart_tx
    import output_interface_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Tx_DV,
    input  logic [7:0] Tx_Byte,
    output logic       Tx_Serial,
    output logic       Tx_Active,
    output logic       Tx_Done
);

    localparam int CNT_W = ($clog2(CLKS_PER_BIT) > 0) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_byte;
    logic             r_serial;
    logic             r_active;
    logic             r_done;
    logic             w_bit_end;

    assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= TX_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_serial <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (Tx_DV) begin
                        r_byte   <= Tx_Byte;
                        r_serial <= 1'b0;
                        r_active <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_cnt    <= '0;
                        r_bit    <= '0;
                        r_serial <= r_byte[0];
                        r_state  <= TX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_serial <= 1'b1;
                            r_state  <= TX_STOP;
                        end else begin
                            r_bit    <= r_bit + 3'd1;
                            r_serial <= r_byte[r_bit + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        r_cnt    <= '0;
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= TX_CLEANUP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                TX_CLEANUP: r_state <= TX_IDLE;
                default:    r_state <= TX_IDLE;
            endcase
        end
    end

    assign Tx_Serial = r_serial;
    assign Tx_Active = r_active;
    assign Tx_Done   = r_done;

endmodule

// File: rtl/output_interface.sv
// Reads a stored picture from BRAM pixel by pixel and sends each pixel as three UART
// bytes (R, G, B), each colour's 6 bits placed in the byte MSBs.
module output_interface
    import output_interface_pkg::*;
#(
    parameter int PIXELS       = PIXELS_DEF,
    parameter int CLKS_PER_BIT = 100,
    parameter int RD_LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PIX_W-1:0]  r_data,
    output logic [ADDR_W-1:0] r_address,
    output logic              uart_tx,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_index;
    logic [PIX_W-1:0]  r_pixel;
    logic [1:0]        r_wait;
    logic              r_busy;
    logic              r_done;
    logic              w_tx_dv;
    logic [7:0]        w_tx_byte;
    logic              w_tx_active;
    logic              w_tx_done;

    // SEND only hands a byte over once the serializer is free, so the valid is a single cycle.
    assign w_tx_dv   = (r_state == SEND) && !w_tx_active;
    assign w_tx_byte = color_byte(r_pixel, r_index);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_index <= '0;
            r_pixel <= '0;
            r_wait  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_addr  <= '0;
                        r_index <= '0;
                        r_wait  <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (r_wait == 2'(RD_LATENCY - 1)) begin
                        r_wait  <= '0;
                        r_state <= LATCH;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                LATCH: begin
                    r_pixel <= r_data;
                    r_state <= SEND;
                end
                SEND: begin
                    if (!w_tx_active) r_state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (w_tx_done) begin
                        if (r_index != 2'd2) begin
                            r_index <= r_index + 2'd1;
                            r_state <= SEND;
                        end else begin
                            r_index <= '0;
                            if (r_addr == ADDR_W'(PIXELS - 1)) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_addr  <= r_addr + 1'b1;
                                r_state <= FETCH;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk      (clk),
        .reset    (reset),
        .Tx_DV    (w_tx_dv),
        .Tx_Byte  (w_tx_byte),
        .Tx_Serial(uart_tx),
        .Tx_Active(w_tx_active),
        .Tx_Done  (w_tx_done)
    );

    assign r_address = r_addr;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
